// File: rtl/multdiv_unit_if.sv
// Handshake bundle between the issue stage and the iterative multiply/divide unit.
// The master drives the operands and the start pulses; the unit returns the result, the ready strobe and busy.
interface multdiv_unit_if;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] ir_in;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic [31:0] ir_out;
    logic        busy;

    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV, ir_in,
        input  data_result, data_exception, data_resultRDY, ir_out, busy
    );

    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV, ir_in,
        output data_result, data_exception, data_resultRDY, ir_out, busy
    );
endinterface

// File: rtl/multdiv_unit.sv
// Iterative 32-bit signed multiply (shift-add) / divide (restoring) unit with a fixed 33-cycle latency.
// Both operations work on operand magnitudes and apply the sign in a final cycle that loads the outputs.
module multdiv_unit (
    input  logic           clock,
    input  logic           reset,
    multdiv_unit_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic [63:0] r_mcand;
    logic [63:0] r_acc;
    logic [31:0] r_oprb;
    logic [31:0] r_quo;
    logic [31:0] r_rem;
    logic        r_neg;
    logic        r_dz;
    logic [31:0] r_result;
    logic        r_exc;
    logic        r_rdy;
    logic [31:0] r_ir;
    logic        r_busy;

    logic        w_start_mul;
    logic        w_start_div;
    logic [32:0] w_rem_shift;
    logic [32:0] w_diff;
    logic [63:0] w_prod;
    logic        w_mul_exc;
    logic [31:0] w_quo;

    function automatic logic [31:0] magnitude(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

    // Start decode (multiply wins a tie), restoring-divide step and final sign correction.
    always_comb begin
        w_start_mul = bus.ctrl_MULT;
        w_start_div = bus.ctrl_DIV & ~bus.ctrl_MULT;
        w_rem_shift = {r_rem, r_quo[31]};
        w_diff      = w_rem_shift - {1'b0, r_oprb};
        w_prod      = r_neg ? (~r_acc + 64'd1) : r_acc;
        w_mul_exc   = (w_prod[63:31] != {33{w_prod[31]}});
        w_quo       = r_neg ? (~r_quo + 32'd1) : r_quo;
    end

    // Control FSM, datapath iteration and registered outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= 6'd0;
            r_mcand  <= 64'd0;
            r_acc    <= 64'd0;
            r_oprb   <= 32'd0;
            r_quo    <= 32'd0;
            r_rem    <= 32'd0;
            r_neg    <= 1'b0;
            r_dz     <= 1'b0;
            r_result <= 32'd0;
            r_exc    <= 1'b0;
            r_rdy    <= 1'b0;
            r_ir     <= 32'd0;
            r_busy   <= 1'b0;
        end else if (w_start_mul || w_start_div) begin
            r_state <= w_start_mul ? S_MUL : S_DIV;
            r_cnt   <= 6'd0;
            r_busy  <= 1'b1;
            r_rdy   <= 1'b0;
            r_ir    <= bus.ir_in;
            r_neg   <= bus.data_operandA[31] ^ bus.data_operandB[31];
            r_dz    <= (bus.data_operandB == 32'd0);
            r_mcand <= {32'd0, magnitude(bus.data_operandA)};
            r_acc   <= 64'd0;
            r_oprb  <= magnitude(bus.data_operandB);
            r_quo   <= magnitude(bus.data_operandA);
            r_rem   <= 32'd0;
        end else begin
            r_rdy <= 1'b0;
            case (r_state)
                S_MUL: begin
                    if (r_cnt == 6'd32) begin
                        r_result <= w_prod[31:0];
                        r_exc    <= w_mul_exc;
                        r_rdy    <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= S_DONE;
                    end else begin
                        if (r_oprb[0]) begin
                            r_acc <= r_acc + r_mcand;
                        end else begin
                            r_acc <= r_acc;
                        end
                        r_mcand <= r_mcand << 1;
                        r_oprb  <= r_oprb >> 1;
                        r_cnt   <= r_cnt + 6'd1;
                    end
                end
                S_DIV: begin
                    if (r_cnt == 6'd32) begin
                        // A positive quotient with bit 31 set can only come from -2^31 / -1.
                        r_result <= r_dz ? 32'd0 : w_quo;
                        r_exc    <= r_dz | (~r_neg & r_quo[31]);
                        r_rdy    <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= S_DONE;
                    end else begin
                        if (!w_diff[32]) begin
                            r_rem <= w_diff[31:0];
                            r_quo <= {r_quo[30:0], 1'b1};
                        end else begin
                            r_rem <= w_rem_shift[31:0];
                            r_quo <= {r_quo[30:0], 1'b0};
                        end
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.data_result    = r_result;
    assign bus.data_exception = r_exc;
    assign bus.data_resultRDY = r_rdy;
    assign bus.ir_out         = r_ir;
    assign bus.busy           = r_busy;
endmodule

// File: tb/tb_multdiv_unit.sv
// Scoreboard bench for multdiv_unit: directed corner cases plus randomized traffic with aborts,
// compared against a plain signed-arithmetic reference model.
module tb_multdiv_unit;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    multdiv_unit_if bus();
    multdiv_unit dut (.clock(clock), .reset(reset), .bus(bus));

    typedef struct {
        logic [31:0] res;
        logic        exc;
        logic [31:0] ir;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] last_res = 32'd0;
    logic        last_exc = 1'b0;
    logic [31:0] last_ir  = 32'd0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input bit m, input logic [31:0] a, input logic [31:0] b, input logic [31:0] ir);
        exp_t   e;
        longint p;
        int     sa, sb_, q;
        sa = a;
        sb_ = b;
        e.ir = ir;
        e.cyc = 0;
        if (m) begin
            p = longint'(sa) * longint'(sb_);
            e.res = p[31:0];
            e.exc = (p != longint'(int'(p[31:0])));
        end else if (b == 32'd0) begin
            e.res = 32'd0;
            e.exc = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.res = 32'h8000_0000;
            e.exc = 1'b1;
        end else begin
            q = sa / sb_;
            e.res = q;
            e.exc = 1'b0;
        end
        return e;
    endfunction

    // Monitor: checks every ready strobe against the scoreboard, held outputs while idle, and busy.
    always @(negedge clock) begin
        if (bus.data_resultRDY) begin
            if (sb.size() == 0) begin
                chk("spurious_rdy", 64'd1, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("rdy_cycle", cyc, mon_e.cyc);
                chk("result", bus.data_result, mon_e.res);
                chk("exception", bus.data_exception, mon_e.exc);
                chk("ir_out", bus.ir_out, mon_e.ir);
                last_res = mon_e.res;
                last_exc = mon_e.exc;
                last_ir  = mon_e.ir;
            end
        end else if (sb.size() == 0) begin
            chk("held_result", bus.data_result, last_res);
            chk("held_exception", bus.data_exception, last_exc);
            chk("held_ir", bus.ir_out, last_ir);
        end
        chk("busy", bus.busy, (sb.size() > 0 && cyc < sb[0].cyc));
    end

    task automatic start(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b, input logic [31:0] ir);
        exp_t e;
        @(negedge clock);
        #1;
        bus.ctrl_MULT = m;
        bus.ctrl_DIV = d;
        bus.data_operandA = a;
        bus.data_operandB = b;
        bus.ir_in = ir;
        e = model(m, a, b, ir);
        e.cyc = cyc + 34;
        sb.delete();
        sb.push_back(e);
        @(posedge clock);
        #1;
        bus.ctrl_MULT = 1'b0;
        bus.ctrl_DIV = 1'b0;
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
        bus.ir_in = $urandom;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            #1;
            if (sb.size() == 0) break;
        end
        if (sb.size() != 0) begin
            chk("timeout", 64'd1, 64'd0);
            sb.delete();
        end
    endtask

    task automatic do_reset(input bit with_start);
        @(negedge clock);
        #1;
        reset = 1'b0;
        bus.ctrl_MULT = with_start;
        bus.data_operandA = 32'd3;
        bus.data_operandB = 32'd3;
        bus.ir_in = 32'hDEAD_BEEF;
        sb.delete();
        last_res = 32'd0;
        last_exc = 1'b0;
        last_ir  = 32'd0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        bus.ctrl_MULT = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bus.ctrl_MULT = 1'b0;
        bus.ctrl_DIV = 1'b0;
        bus.data_operandA = 32'd0;
        bus.data_operandB = 32'd0;
        bus.ir_in = 32'd0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clock);

        start(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFA, 32'h1234_5678);
        wait_idle();
        start(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001);
        wait_idle();
        start(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0002);
        wait_idle();
        start(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'h0000_0003);
        wait_idle();
        start(1'b0, 1'b1, 32'd100, 32'hFFFF_FFF6, 32'h0000_0004);
        wait_idle();
        start(1'b0, 1'b1, 32'd5, 32'd0, 32'h0000_0005);
        wait_idle();
        start(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0006);
        wait_idle();

        start(1'b0, 1'b1, 32'd1000, 32'd7, 32'h0000_0007);
        repeat (9) @(posedge clock);
        start(1'b1, 1'b0, 32'd3, 32'd4, 32'h0000_0008);
        wait_idle();
        start(1'b1, 1'b1, 32'd6, 32'd5, 32'h0000_0009);
        wait_idle();

        // Back-to-back: the next start lands in the DONE cycle of the previous operation.
        start(1'b1, 1'b0, 32'hFFFF_FF00, 32'd300, 32'h0000_000A);
        repeat (33) @(posedge clock);
        start(1'b0, 1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFD, 32'h0000_000B);
        wait_idle();

        start(1'b1, 1'b0, 32'd9, 32'd9, 32'h0000_000C);
        repeat (19) @(posedge clock);
        do_reset(1'b0);
        repeat (40) @(posedge clock);
        do_reset(1'b1);
        repeat (5) @(posedge clock);

        for (int n = 0; n < 40; n++) begin
            logic m, d;
            m = $urandom_range(0, 1);
            d = ~m | ($urandom_range(0, 3) == 0);
            start(m, d, pick(), pick(), $urandom);
            if ($urandom_range(0, 4) == 0) begin
                repeat ($urandom_range(1, 34)) @(posedge clock);
            end else begin
                wait_idle();
                repeat ($urandom_range(0, 3)) @(posedge clock);
            end
        end
        wait_idle();
        repeat (3) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/multdiv_unit.md
# multdiv_unit

Iterative 32-bit signed multiply/divide unit that sits directly upstream of the product/writeback pipeline latch. It accepts a one-cycle start pulse with two operands and the issuing instruction word. It computes the result over a fixed number of cycles, then presents result, exception flag, one-cycle ready strobe and the captured instruction word for the latch to load.

## Interface
- No parameters; data width fixed at 32.
- `clock` input 1: the only clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-low; sampled on the rising edge of `clock`.
- `data_operandA` input 32: multiplicand / dividend, two's complement; sampled only on a start edge.
- `data_operandB` input 32: multiplier / divisor, two's complement; sampled only on a start edge.
- `ctrl_MULT` input 1: start-multiply pulse.
- `ctrl_DIV` input 1: start-divide pulse.
- `ir_in` input 32: issuing instruction word; sampled only on a start edge.
- `data_result` output 32: product low word or quotient; registered; held until the next start.
- `data_exception` output 1: overflow or divide-by-zero flag; registered; held with `data_result`.
- `data_resultRDY` output 1: high for exactly one cycle when the result is valid.
- `ir_out` output 32: instruction word captured at start; held until the next start.
- `busy` output 1: high while an operation is in progress (states MUL, DIV).

## Operation
- States: IDLE, MUL, DIV, DONE. A 6-bit iteration counter runs 0..31.
- Start edge: a rising edge with `ctrl_MULT` or `ctrl_DIV` high and `reset` high. A start is accepted in any state and aborts any operation in flight.
  - The abandoned operation never raises `data_resultRDY`.
  - If both controls are high, multiply wins.
- On a start edge:
  - capture operands and `ir_in` into `ir_out`;
  - clear the counter;
  - go to MUL or DIV;
  - drop `data_resultRDY`.
- MUL: radix-2 shift-add on operand magnitudes, with a 64-bit accumulator; one iteration per cycle; 32 iterations.
  - Sign fix at the end: negate the product if the operand signs differ.
  - `data_result` = product[31:0].
  - `data_exception` = 1 when product[63:31] is not all-equal, i.e. the result does not fit in 32 bits signed.
- DIV: restoring division on magnitudes; 32 iterations.
  - Quotient negated if the signs differ; truncates toward zero. The remainder is discarded.
  - Divisor = 0: detected at start; iterations still run; final `data_result` = 0, `data_exception` = 1.
  - 0x80000000 / 0xFFFFFFFF: `data_result` = 0x80000000, `data_exception` = 1.
- After the 32nd iteration: go to DONE, load `data_result` and `data_exception`, and assert `data_resultRDY`.
- DONE lasts one cycle, then IDLE.
- IDLE and DONE hold result, exception and `ir_out` unchanged.
- Reset (low on an edge) overrides everything, including a simultaneous start.
  - Next state IDLE.
  - `data_result` = 0, `data_exception` = 0, `data_resultRDY` = 0, `ir_out` = 0, `busy` = 0, counter = 0.
  - Reset mid-operation discards the operation with no ready strobe.

## Timing
- Start on edge 0 means: `busy` high after edges 0..32; `data_resultRDY` high only in the cycle after edge 33.
- Latency is 33 cycles for every operation, including divide-by-zero and overflow cases.
- `data_result`, `data_exception` and `ir_out` are valid and stable in the `data_resultRDY` cycle and remain so until the next start edge.
- Back-to-back: a start may arrive in the DONE cycle. The ready strobe for the finished result is still visible that cycle; the new operation begins at that edge.
- All outputs come straight from registers; there is no combinational path from any input to any output.

## Test plan
- Multiply 7 × 0xFFFFFFFA (−6), `ir_in` = 0x12345678 → after 33 cycles: `data_result` 0xFFFFFFD6, exception 0, RDY high for one cycle, `ir_out` 0x12345678; `busy` high for cycles 1–33.
- Multiply 0x00010000 × 0x00010000 → result 0x00000000, exception 1. Then 0xFFFFFFFF × 0xFFFFFFFF → 0x00000001, exception 0.
- Divide 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD, exception 0. Then 100 / 0xFFFFFFF6 (−10) → 0xFFFFFFF6, exception 0.
- Divide 5 / 0 → 0x00000000, exception 1, at cycle 33. Then 0x80000000 / 0xFFFFFFFF → 0x80000000, exception 1.
- Start a divide; pulse `ctrl_MULT` (3 × 4) at cycle 10 → no RDY for the divide; RDY exactly 33 cycles after the new start, result 0x0000000C. Also assert both controls together → the multiply result is produced.
- Reset low at cycle 20 of a multiply → all outputs 0 at the next edge, RDY never rises. Start and reset asserted on the same edge → stays IDLE, `busy` 0.
